sequence_playback: RTL

SEQUENCE_PLAYBACK -- requirements
Module: sequence_playback

---
 rtl/sequence_playback_if.sv | 25 ++
 rtl/sequence_playback.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sequence_playback_if.sv
// rtl/sequence_playback_if.sv - Control and display bundle for the sequence player
interface sequence_playback_if #(
    parameter int NUM_SEG = 32
);
    logic                   start;
    logic                   abort;
    logic [5:0]             round_len;
    logic [NUM_SEG*3-1:0]   segment;
    logic                   pulse;
    logic [3:0]             led;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [5:0]             pos;

    modport master (
        output start, abort, round_len, segment, pulse,
        input  led, busy, done, err, pos
    );

    modport slave (
        input  start, abort, round_len, segment, pulse,
        output led, busy, done, err, pos
    );
endinterface

// File: rtl/sequence_playback.sv
// rtl/sequence_playback.sv - Plays back a snapshot of colour history on one-hot LEDs
module sequence_playback #(
    parameter int NUM_SEG   = 32,
    parameter int GAP_TICKS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    sequence_playback_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ON, OFF, FIN} state_t;

    localparam logic [5:0] MAX_LEN  = 6'(NUM_SEG);
    localparam logic [2:0] GAP_LAST = 3'(GAP_TICKS - 1);

    state_t                   state, state_next;
    logic [NUM_SEG-1:0][2:0]  snap;
    logic [5:0]               len;
    logic [5:0]               pos;
    logic [2:0]               gap;
    logic                     err_q;

    logic                     accept, pos_inc, gap_clr, gap_inc, err_set;
    logic [3:0]               led_c;
    logic                     busy_c, done_c, err_c;
    logic [5:0]               clamped_len;
    logic [5:0]               idx;
    logic [2:0]               entry;
    logic [6:0]               pos_plus;
    logic                     last_colour;

    assign clamped_len = (bus.round_len > MAX_LEN) ? MAX_LEN : bus.round_len;
    // Oldest colour sits at the highest snapshot index, so count down from len-1.
    assign idx         = len - 6'd1 - pos;
    assign pos_plus    = {1'b0, pos} + 7'd1;
    assign last_colour = pos_plus >= {1'b0, len};

    // Select the snapshot entry for the colour currently playing.
    always_comb begin
        entry = '0;
        for (int i = 0; i < NUM_SEG; i++) begin
            if (idx == 6'(i)) begin
                entry = snap[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and display/status outputs; abort outranks pulse and start.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        pos_inc    = 1'b0;
        gap_clr    = 1'b0;
        gap_inc    = 1'b0;
        err_set    = 1'b0;
        led_c      = 4'b0000;
        busy_c     = (state != IDLE);
        done_c     = 1'b0;
        err_c      = err_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = (clamped_len == 6'd0) ? FIN : ON;
                end
            end
            ON: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (entry[2]) begin
                    err_set    = 1'b1;
                    err_c      = 1'b1;
                    state_next = FIN;
                end else begin
                    led_c = 4'b0001 << entry[1:0];
                    if (bus.pulse) begin
                        gap_clr    = 1'b1;
                        state_next = OFF;
                    end
                end
            end
            OFF: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (bus.pulse) begin
                    if (gap == GAP_LAST) begin
                        if (last_colour) begin
                            state_next = FIN;
                        end else begin
                            pos_inc    = 1'b1;
                            state_next = ON;
                        end
                    end else begin
                        gap_inc = 1'b1;
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
                if (!bus.abort) begin
                    done_c = !err_q;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Snapshot, position, gap counter and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap  <= '0;
            len   <= '0;
            pos   <= '0;
            gap   <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                snap  <= bus.segment;
                len   <= clamped_len;
                pos   <= '0;
                err_q <= 1'b0;
            end
            if (pos_inc) begin
                pos <= pos + 6'd1;
            end
            if (gap_clr) begin
                gap <= '0;
            end else if (gap_inc) begin
                gap <= gap + 3'd1;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.led  = led_c;
    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.err  = err_c;
    assign bus.pos  = pos;
endmodule
